// File: rtl/modport_apb_gpio_pkg.sv
// Shared constants for the APB GPIO controller: register word offsets,
// CTRL bit positions and the default GPIO width.
package modport_apb_gpio_pkg;

  localparam int GPIO_W_DEFAULT = 32;

  // Word offsets, compared against PADDR[7:2]
  localparam logic [5:0] ADDR_IN    = 6'h00;
  localparam logic [5:0] ADDR_OUT   = 6'h01;
  localparam logic [5:0] ADDR_OE    = 6'h02;
  localparam logic [5:0] ADDR_INTE  = 6'h03;
  localparam logic [5:0] ADDR_PTRIG = 6'h04;
  localparam logic [5:0] ADDR_CTRL  = 6'h05;
  localparam logic [5:0] ADDR_INTS  = 6'h06;

  localparam int GIE_BIT = 0;

endpackage

// File: rtl/modport_apb_gpio_sync_edge.sv
// Two-flop synchronizer for asynchronous pad inputs plus a history register
// that yields per-bit rising/falling edge strobes on the synchronized value.
module gpio_sync_edge
  import modport_apb_gpio_pkg::*;
#(
  parameter int W = GPIO_W_DEFAULT
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1_reg;
  logic [W-1:0] s2_reg;
  logic [W-1:0] prev_reg;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      prev_reg <= '0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  assign sync = s2_reg;

  for (genvar gi = 0; gi < W; gi++) begin : g_edge
    assign rise[gi] =  s2_reg[gi] & ~prev_reg[gi];
    assign fall[gi] = ~s2_reg[gi] &  prev_reg[gi];
  end

endmodule

// File: rtl/modport_apb_gpio.sv
// APB3 zero-wait-state GPIO controller: output/enable registers, synchronized
// inputs, per-bit edge interrupts with W1C status and a registered IRQ.
module modport_apb_gpio
  import modport_apb_gpio_pkg::*;
#(
  parameter int GPIO_W = GPIO_W_DEFAULT
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              IRQ,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe
);

  logic [GPIO_W-1:0] out_reg,   out_next;
  logic [GPIO_W-1:0] oe_reg,    oe_next;
  logic [GPIO_W-1:0] inte_reg,  inte_next;
  logic [GPIO_W-1:0] ptrig_reg, ptrig_next;
  logic [GPIO_W-1:0] ints_reg,  ints_next;
  logic              gie_reg,   gie_next;
  logic              irq_reg,   irq_next;

  logic [GPIO_W-1:0] in_sync, rise, fall, edge_hit, w1c;
  logic [5:0]        reg_idx;
  logic              wr_en;
  logic              unused_bits;

  assign reg_idx     = PADDR[7:2];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

  gpio_sync_edge #(.W(GPIO_W)) u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .din     (gpio_in),
    .sync    (in_sync),
    .rise    (rise),
    .fall    (fall)
  );

  for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_trig
    assign edge_hit[gi] = ptrig_reg[gi] ? rise[gi] : fall[gi];
  end

  always_comb begin
    out_next   = out_reg;
    oe_next    = oe_reg;
    inte_next  = inte_reg;
    ptrig_next = ptrig_reg;
    gie_next   = gie_reg;
    w1c        = '0;
    if (wr_en) begin
      case (reg_idx)
        ADDR_OUT:   out_next   = PWDATA[GPIO_W-1:0];
        ADDR_OE:    oe_next    = PWDATA[GPIO_W-1:0];
        ADDR_INTE:  inte_next  = PWDATA[GPIO_W-1:0];
        ADDR_PTRIG: ptrig_next = PWDATA[GPIO_W-1:0];
        ADDR_CTRL:  gie_next   = PWDATA[GIE_BIT];
        ADDR_INTS:  w1c        = PWDATA[GPIO_W-1:0];
        default:    ;
      endcase
    end
    // A fresh edge outranks a simultaneous clear of the same bit
    ints_next = (ints_reg & ~w1c) | (edge_hit & inte_reg);
    irq_next  = gie_next & (|ints_next);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      out_reg   <= '0;
      oe_reg    <= '0;
      inte_reg  <= '0;
      ptrig_reg <= '0;
      ints_reg  <= '0;
      gie_reg   <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      out_reg   <= out_next;
      oe_reg    <= oe_next;
      inte_reg  <= inte_next;
      ptrig_reg <= ptrig_next;
      ints_reg  <= ints_next;
      gie_reg   <= gie_next;
      irq_reg   <= irq_next;
    end
  end

  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      case (reg_idx)
        ADDR_IN:    PRDATA = 32'(in_sync);
        ADDR_OUT:   PRDATA = 32'(out_reg);
        ADDR_OE:    PRDATA = 32'(oe_reg);
        ADDR_INTE:  PRDATA = 32'(inte_reg);
        ADDR_PTRIG: PRDATA = 32'(ptrig_reg);
        ADDR_CTRL:  PRDATA[GIE_BIT] = gie_reg;
        ADDR_INTS:  PRDATA = 32'(ints_reg);
        default:    PRDATA = 32'h0;
      endcase
    end
  end

  assign PREADY   = 1'b1;
  assign IRQ      = irq_reg;
  assign gpio_out = out_reg;
  assign gpio_oe  = oe_reg;

endmodule

// File: tb/tb_modport_apb_gpio.sv
// Self-checking bench for modport_apb_gpio: APB reads push expected data to a
// scoreboard queue that is popped and compared when the read data is sampled.
module tb_modport_apb_gpio;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, IRQ;
  logic [31:0] gpio_in, gpio_out, gpio_oe;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 PCLK = ~PCLK;

  modport_apb_gpio #(.GPIO_W(32)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .IRQ     (IRQ),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered 1 time unit after a rising edge
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("wr  addr=%h data=%h", addr, data);
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      $display("rd  addr=%h data=%h exp=%h", addr, PRDATA, e);
      chk(t, PRDATA, e);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; gpio_in = '0;

    // Reset
    @(posedge PCLK); #1;
    chk("pready_in_reset", {31'd0, PREADY}, 32'd1);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    chk("irq_reset", {31'd0, IRQ}, 32'd0);
    chk("oe_reset", gpio_oe, 32'd0);
    chk("out_reset", gpio_out, 32'd0);
    for (int i = 0; i < 7; i++) apb_read(32'(i * 4), 32'd0, $sformatf("reset_rd_%0d", i));
    chk("pready", {31'd0, PREADY}, 32'd1);

    // Write / readback
    apb_write(32'h04, 32'hA5A5_5A5A);
    chk("gpio_out", gpio_out, 32'hA5A5_5A5A);
    apb_read(32'h04, 32'hA5A5_5A5A, "out_rd");
    apb_read(32'hFFFF_FF05, 32'hA5A5_5A5A, "out_alias_rd");
    apb_write(32'h08, 32'hFFFF_0000);
    chk("gpio_oe", gpio_oe, 32'hFFFF_0000);
    apb_read(32'h08, 32'hFFFF_0000, "oe_rd");
    apb_write(32'h00, 32'h0000_1234);
    apb_read(32'h00, 32'h0, "in_ro");
    apb_read(32'h40, 32'h0, "unmapped_rd");
    apb_write(32'h14, 32'hFFFF_FFFF);
    apb_read(32'h14, 32'h1, "ctrl_rd");
    PSEL = 1'b0; PADDR = 32'h04; #1;
    chk("prdata_idle", PRDATA, 32'h0);

    // Rising edge on bit 0
    apb_write(32'h0C, 32'h1);
    apb_write(32'h10, 32'h1);
    apb_write(32'h14, 32'h1);
    gpio_in[0] = 1'b1;
    idle(2);
    chk("irq_not_yet", {31'd0, IRQ}, 32'd0);
    idle(1);
    chk("irq_rise", {31'd0, IRQ}, 32'd1);
    apb_read(32'h18, 32'h1, "ints_rise");
    apb_read(32'h00, 32'h1, "in_rd");
    apb_write(32'h18, 32'h1);
    chk("irq_cleared", {31'd0, IRQ}, 32'd0);
    apb_read(32'h18, 32'h0, "ints_cleared");

    // Falling edge on bit 3, first masked then enabled
    gpio_in[3] = 1'b1;
    idle(4);
    gpio_in[3] = 1'b0;
    idle(4);
    apb_read(32'h18, 32'h0, "ints_masked");
    gpio_in[3] = 1'b1;
    idle(4);
    apb_write(32'h0C, 32'h9);
    gpio_in[3] = 1'b0;
    idle(4);
    apb_read(32'h18, 32'h8, "ints_fall");
    chk("irq_fall", {31'd0, IRQ}, 32'd1);
    apb_write(32'h14, 32'h0);
    chk("irq_gie_off", {31'd0, IRQ}, 32'd0);
    apb_read(32'h18, 32'h8, "ints_kept");
    apb_write(32'h18, 32'h8);
    apb_write(32'h14, 32'h1);

    // Clear of bit 0 lands on the same edge a new rise sets it
    gpio_in[0] = 1'b0;
    idle(4);
    gpio_in[0] = 1'b1;
    idle(4);
    apb_read(32'h18, 32'h1, "ints_pre_coll");
    gpio_in[0] = 1'b0;
    idle(4);
    gpio_in[0] = 1'b1;
    @(posedge PCLK); #1;
    apb_write(32'h18, 32'h1);
    apb_read(32'h18, 32'h1, "ints_collision");
    chk("irq_collision", {31'd0, IRQ}, 32'd1);

    // Reset asserted on the access-phase edge of a write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'hFFFF_FFFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESETn = 1'b1;
    $display("wr  addr=00000004 data=ffffffff under reset");
    chk("out_after_rst", gpio_out, 32'h0);
    chk("irq_after_rst", {31'd0, IRQ}, 32'd0);
    apb_read(32'h04, 32'h0, "out_rd_after_rst");
    apb_read(32'h18, 32'h0, "ints_after_rst");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
